// File: rtl/eth_pkg.sv
// Shared Ethernet constants: preamble/SFD bytes, frame limits, CRC-32
// parameters, RGMII control encodings and the TX framer state encoding.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Minimum frame length before FCS (64-byte frame minus 4-byte FCS)
    localparam logic [10:0] MIN_FRAME     = 11'd60;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam logic [31:0] CRC_PRESET    = 32'hFFFFFFFF;

    // RGMII ctl: bit 0 = TX_EN, bit 1 = TX_EN ^ TX_ER
    localparam logic [1:0]  CTL_IDLE      = 2'b00;
    localparam logic [1:0]  CTL_DATA      = 2'b11;
    localparam logic [1:0]  CTL_ERR       = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DRAIN
    } state_e;

    // Bit-reverse a 32-bit word (normal <-> reflected polynomial form)
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational reflected CRC-32 update for one byte (LSB-first bit order).
// Shared between the TX framer and the receive FCS checker.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    // Eight unrolled shift/XOR steps, data folded into the low byte first
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet TX framer feeding the RGMII DDR output multiplexer.
// Adds preamble/SFD and inter-frame gap; aborts on underrun or oversize.
// Build option ETH_TX_FCS_EN: when defined, pads to 60 bytes and appends
// the FCS; when undefined the source supplies padded frames with FCS.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MAX_LEN   = 1514,
    parameter int IFG_BYTES = 12
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  phy_tx_mux_data,
    output logic [1:0]  phy_tx_mux_ctl,
    output logic [15:0] frame_count,
    output logic [15:0] error_count
);

    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
    // The first IFG cycle still shows the final frame byte from the output
    // register, so the state lasts one extra cycle to give IFG_BYTES idles.
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_BYTES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  ctl_q, ctl_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_d, crc_next;
    logic [7:0]  crc_byte;

    assign crc_byte = (state_q == ST_PAD) ? 8'h00 : in_data;

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (crc_byte),
        .crc_out (crc_next)
    );
`endif

    assign in_ready        = (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign phy_tx_mux_data = data_q;
    assign phy_tx_mux_ctl  = ctl_q;
    assign frame_count     = frame_cnt_q;
    assign error_count     = err_cnt_q;

    // Next state and the byte/ctl to present on the following cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        data_d      = 8'h00;
        ctl_d       = CTL_IDLE;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
`ifdef ETH_TX_FCS_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = 8'd1;
                    data_d  = PREAMBLE_BYTE;
                    ctl_d   = CTL_DATA;
                end
            end
            ST_PREAMBLE: begin
                ctl_d = CTL_DATA;
                if (cnt_q == 8'd7) begin
                    data_d  = SFD_BYTE;
                    state_d = ST_DATA;
                    len_d   = 11'd0;
`ifdef ETH_TX_FCS_EN
                    crc_d   = CRC_PRESET;
`endif
                end else begin
                    data_d = PREAMBLE_BYTE;
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    len_d  = len_q + 11'd1;
                    data_d = in_data;
                    ctl_d  = CTL_DATA;
`ifdef ETH_TX_FCS_EN
                    crc_d  = crc_next;
`endif
                    if (in_last) begin
                        cnt_d = 8'd0;
`ifdef ETH_TX_FCS_EN
                        state_d = (len_d < MIN_FRAME) ? ST_PAD : ST_FCS;
`else
                        state_d     = ST_IFG;
                        frame_cnt_d = frame_cnt_q + 16'd1;
`endif
                    end else if (len_d == MAX_LEN_L) begin
                        ctl_d     = CTL_ERR;
                        err_cnt_d = err_cnt_q + 16'd1;
                        state_d   = ST_DRAIN;
                    end
                end else begin
                    // Underrun: flag TX_ER for one byte time and abandon the frame
                    ctl_d     = CTL_ERR;
                    err_cnt_d = err_cnt_q + 16'd1;
                    state_d   = ST_DRAIN;
                end
            end
`ifdef ETH_TX_FCS_EN
            ST_PAD: begin
                ctl_d = CTL_DATA;
                crc_d = crc_next;
                len_d = len_q + 11'd1;
                if (len_d == MIN_FRAME) begin
                    state_d = ST_FCS;
                    cnt_d   = 8'd0;
                end
            end
            ST_FCS: begin
                // Shift the CRC out low byte first, complemented
                ctl_d  = CTL_DATA;
                data_d = ~crc_q[7:0];
                crc_d  = {8'h00, crc_q[31:8]};
                if (cnt_q == 8'd3) begin
                    state_d     = ST_IFG;
                    cnt_d       = 8'd0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            ST_DRAIN: begin
                if (in_valid && in_last) begin
                    state_d = ST_IFG;
                    cnt_d   = 8'd0;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered PHY outputs; reset forces idle at once
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            len_q       <= 11'd0;
            data_q      <= 8'h00;
            ctl_q       <= CTL_IDLE;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            data_q      <= data_d;
            ctl_q       <= ctl_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef ETH_TX_FCS_EN
    // Running CRC register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            crc_q <= CRC_PRESET;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: random payloads are compared
// against a frame-level reference model of the expected wire stream.
module tb_eth_tx_framer;

    localparam int MAX_LEN   = 1514;
    localparam int IFG_BYTES = 12;

    typedef logic [7:0] bq_t[$];
    typedef logic [9:0] sq_t[$];

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  phy_tx_mux_data;
    logic [1:0]  phy_tx_mux_ctl;
    logic [15:0] frame_count;
    logic [15:0] error_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_frames = 0;
    int exp_errs = 0;

    sq_t cap_v;
    int  cap_c[$];

    eth_tx_framer #(.MAX_LEN(MAX_LEN), .IFG_BYTES(IFG_BYTES)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .phy_tx_mux_data (phy_tx_mux_data),
        .phy_tx_mux_ctl  (phy_tx_mux_ctl),
        .frame_count     (frame_count),
        .error_count     (error_count)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every non-idle output byte with its cycle number
    always @(negedge clk) begin
        if (phy_tx_mux_ctl != 2'b00) begin
            cap_v.push_back({phy_tx_mux_ctl, phy_tx_mux_data});
            cap_c.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

`ifdef ETH_TX_FCS_EN
    // Bit-serial reflected CRC-32 straight from the definition
    function automatic logic [31:0] ref_crc(input bq_t b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h00000000);
            end
        end
        return c;
    endfunction
`endif

    // Expected active wire stream {ctl, data} for one frame
    function automatic sq_t expect_stream(input bq_t pl, input int underrun_after);
        sq_t s;
        int  n;
`ifdef ETH_TX_FCS_EN
        bq_t body;
        logic [31:0] fcs;
`endif
        n = pl.size();
        for (int i = 0; i < 7; i++) s.push_back({2'b11, 8'h55});
        s.push_back({2'b11, 8'hD5});
        for (int i = 0; i < n; i++) begin
            if (i == underrun_after) begin
                s.push_back({2'b01, 8'h00});
                return s;
            end
            if (n > MAX_LEN && i == MAX_LEN - 1) begin
                s.push_back({2'b01, pl[i]});
                return s;
            end
            s.push_back({2'b11, pl[i]});
`ifdef ETH_TX_FCS_EN
            body.push_back(pl[i]);
`endif
        end
`ifdef ETH_TX_FCS_EN
        while (body.size() < 60) begin
            body.push_back(8'h00);
            s.push_back({2'b11, 8'h00});
        end
        fcs = ~ref_crc(body);
        for (int k = 0; k < 4; k++) s.push_back({2'b11, fcs[8*k +: 8]});
`endif
        return s;
    endfunction

    function automatic int first_diff(input sq_t got, input sq_t want);
        int n;
        n = (got.size() < want.size()) ? got.size() : want.size();
        for (int i = 0; i < n; i++) if (got[i] !== want[i]) return i;
        if (got.size() != want.size()) return n;
        return -1;
    endfunction

    function automatic logic [9:0] at(input sq_t q, input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 'x;
    endfunction

    function automatic bq_t rand_payload(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic clear_capture();
        cap_v.delete();
        cap_c.delete();
    endtask

    // Feed a payload; optional valid gap after drop_after bytes, optional
    // asynchronous reset once abort_at bytes have been accepted.
    task automatic drive(input bq_t pl, input int drop_after, input int drop_len,
                         input int abort_at, output int start_cyc, output int accepted);
        int  i;
        int  budget;
        bit  dropped;
        i = 0; budget = 0; dropped = 0; start_cyc = -1;
        while (i < pl.size()) begin
            @(negedge clk);
            if (abort_at >= 0 && i == abort_at) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                #1 nreset = 1'b0;
                accepted = i;
                return;
            end
            if (!dropped && drop_after >= 0 && i == drop_after) begin
                dropped  = 1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat (drop_len) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = pl[i];
            in_last  = (i == pl.size() - 1);
            if (start_cyc < 0) start_cyc = cyc;
            if (in_ready) i++;
            budget++;
            if (budget > 4000) begin
                checks++;
                errors++;
                $display("FAIL drive_budget: accepted %0d of %0d bytes", i, pl.size());
                break;
            end
        end
        accepted = i;
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (phy_tx_mux_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", phy_tx_mux_data); end
        checks++; if (phy_tx_mux_ctl !== 2'b00) begin errors++; $display("FAIL rst_ctl: got %b want 00", phy_tx_mux_ctl); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frames: got %0d want 0", frame_count); end
        checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL rst_errors: got %0d want 0", error_count); end
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || phy_tx_mux_ctl !== 2'b00) begin errors++; $display("FAIL idle_quiet: ready %b ctl %b want 0 00", in_ready, phy_tx_mux_ctl); end
    endtask

    task automatic test_frame_64();
        bq_t pl; sq_t exp; int s, acc, d, last;
`ifdef ETH_TX_FCS_EN
        bq_t wire_b; logic [31:0] r, rev;
`endif
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        clear_capture();
        drive(pl, -1, 0, -1, s, acc);
        settle(90);
        exp_frames++;
        exp = expect_stream(pl, -1);
        d = first_diff(cap_v, exp);
        checks++; if (d != -1) begin errors++; $display("FAIL stream_64: entry %0d got %h want %h (entries %0d want %0d)", d, at(cap_v, d), at(exp, d), cap_v.size(), exp.size()); end
`ifdef ETH_TX_FCS_EN
        checks++; if (cap_v.size() != 76) begin errors++; $display("FAIL total_64: got %0d active cycles want 76", cap_v.size()); end
`else
        checks++; if (cap_v.size() != 72) begin errors++; $display("FAIL total_64: got %0d active cycles want 72", cap_v.size()); end
`endif
        checks++; if ((cap_c.size() > 0 ? cap_c[0] : -1) != s + 1) begin errors++; $display("FAIL preamble_latency: got cycle %0d want %0d", cap_c.size() > 0 ? cap_c[0] : -1, s + 1); end
        checks++; if ((cap_c.size() > 7 ? cap_c[7] : -1) != s + 8) begin errors++; $display("FAIL sfd_latency: got cycle %0d want %0d", cap_c.size() > 7 ? cap_c[7] : -1, s + 8); end
        last = cap_c.size() - 1;
        checks++; if (last < 0 || cap_c[last] - cap_c[0] != last) begin errors++; $display("FAIL contiguous_64: span %0d want %0d", last < 0 ? -1 : cap_c[last] - cap_c[0], last); end
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL frames_64: got %0d want %0d", frame_count, exp_frames); end
`ifdef ETH_TX_FCS_EN
        for (int i = 8; i < cap_v.size(); i++) wire_b.push_back(cap_v[i][7:0]);
        r   = ref_crc(wire_b);
        rev = {<<{r}};
        checks++; if (rev !== 32'hC704DD7B) begin errors++; $display("FAIL residue_64: got %h want C704DD7B", rev); end
`endif
    endtask

    task automatic test_short_frame();
        bq_t pl; sq_t exp; int s, acc, d;
        pl.push_back(8'hAB);
        clear_capture();
        drive(pl, -1, 0, -1, s, acc);
        settle(90);
        exp_frames++;
        exp = expect_stream(pl, -1);
        d = first_diff(cap_v, exp);
        checks++; if (d != -1) begin errors++; $display("FAIL stream_short: entry %0d got %h want %h", d, at(cap_v, d), at(exp, d)); end
`ifdef ETH_TX_FCS_EN
        checks++; if (cap_v.size() != 72) begin errors++; $display("FAIL total_short: got %0d want 72", cap_v.size()); end
`else
        checks++; if (cap_v.size() != 9) begin errors++; $display("FAIL total_short: got %0d want 9", cap_v.size()); end
`endif
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL frames_short: got %0d want %0d", frame_count, exp_frames); end
    endtask

    task automatic test_random_frames();
        bq_t pl; sq_t exp; int s, acc, d;
        for (int f = 0; f < 5; f++) begin
            pl = rand_payload($urandom_range(1, 120));
            clear_capture();
            drive(pl, -1, 0, -1, s, acc);
            settle(90);
            exp_frames++;
            exp = expect_stream(pl, -1);
            d = first_diff(cap_v, exp);
            checks++; if (d != -1) begin errors++; $display("FAIL stream_rand%0d: len %0d entry %0d got %h want %h", f, pl.size(), d, at(cap_v, d), at(exp, d)); end
        end
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL frames_rand: got %0d want %0d", frame_count, exp_frames); end
    endtask

    task automatic test_back_to_back();
        bq_t p1, p2; sq_t exp, e2; int s, acc, d, idx, gap;
        p1 = rand_payload(60);
        p2 = rand_payload(60);
        clear_capture();
        drive(p1, -1, 0, -1, s, acc);
        drive(p2, -1, 0, -1, s, acc);
        settle(90);
        exp_frames += 2;
        exp = expect_stream(p1, -1);
        idx = exp.size();
        e2 = expect_stream(p2, -1);
        foreach (e2[i]) exp.push_back(e2[i]);
        d = first_diff(cap_v, exp);
        checks++; if (d != -1) begin errors++; $display("FAIL stream_b2b: entry %0d got %h want %h", d, at(cap_v, d), at(exp, d)); end
        gap = (cap_c.size() > idx) ? cap_c[idx] - cap_c[idx-1] - 1 : -1;
        checks++; if (gap != IFG_BYTES + 1) begin errors++; $display("FAIL ifg_gap: got %0d idle cycles want %0d", gap, IFG_BYTES + 1); end
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL frames_b2b: got %0d want %0d", frame_count, exp_frames); end
    endtask

    task automatic test_underrun();
        bq_t pl; sq_t exp; int s, acc, d, nerr;
        pl = rand_payload(40);
        clear_capture();
        drive(pl, 20, 5, -1, s, acc);
        settle(90);
        exp_errs++;
        exp = expect_stream(pl, 20);
        d = first_diff(cap_v, exp);
        checks++; if (d != -1) begin errors++; $display("FAIL stream_underrun: entry %0d got %h want %h", d, at(cap_v, d), at(exp, d)); end
        nerr = 0;
        foreach (cap_v[i]) if (cap_v[i][9:8] == 2'b01) nerr++;
        checks++; if (nerr != 1) begin errors++; $display("FAIL txer_cycles: got %0d want 1", nerr); end
        checks++; if (acc != 40) begin errors++; $display("FAIL underrun_drain: accepted %0d want 40", acc); end
        checks++; if (error_count !== 16'(exp_errs)) begin errors++; $display("FAIL errors_underrun: got %0d want %0d", error_count, exp_errs); end
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL frames_underrun: got %0d want %0d", frame_count, exp_frames); end
    endtask

    task automatic test_oversize();
        bq_t pl; sq_t exp; int s, acc, d;
        pl = rand_payload(1600);
        clear_capture();
        drive(pl, -1, 0, -1, s, acc);
        settle(90);
        exp_errs++;
        exp = expect_stream(pl, -1);
        d = first_diff(cap_v, exp);
        checks++; if (d != -1) begin errors++; $display("FAIL stream_oversize: entry %0d got %h want %h", d, at(cap_v, d), at(exp, d)); end
        checks++; if (acc != 1600) begin errors++; $display("FAIL oversize_drain: accepted %0d want 1600", acc); end
        checks++; if (error_count !== 16'(exp_errs)) begin errors++; $display("FAIL errors_oversize: got %0d want %0d", error_count, exp_errs); end
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL frames_oversize: got %0d want %0d", frame_count, exp_frames); end
    endtask

    task automatic test_reset_mid_frame();
        bq_t pl; sq_t exp, full; int s, acc, d;
        pl = rand_payload(64);
        clear_capture();
        drive(pl, -1, 0, 30, s, acc);
        #1;
        checks++; if (phy_tx_mux_ctl !== 2'b00 || phy_tx_mux_data !== 8'h00) begin errors++; $display("FAIL async_reset: ctl %b data %h want 00 00", phy_tx_mux_ctl, phy_tx_mux_data); end
        repeat (4) @(negedge clk);
        exp_frames = 0;
        exp_errs = 0;
        full = expect_stream(pl, -1);
        for (int i = 0; i < 38; i++) exp.push_back(full[i]);
        d = first_diff(cap_v, exp);
        checks++; if (d != -1) begin errors++; $display("FAIL stream_aborted: entry %0d got %h want %h", d, at(cap_v, d), at(exp, d)); end
        checks++; if (frame_count !== 16'd0 || error_count !== 16'd0) begin errors++; $display("FAIL counters_after_reset: frames %0d errors %0d want 0 0", frame_count, error_count); end
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        pl = rand_payload($urandom_range(1, 80));
        clear_capture();
        drive(pl, -1, 0, -1, s, acc);
        settle(90);
        exp_frames++;
        exp = expect_stream(pl, -1);
        d = first_diff(cap_v, exp);
        checks++; if (d != -1) begin errors++; $display("FAIL stream_post_reset: entry %0d got %h want %h", d, at(cap_v, d), at(exp, d)); end
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL frames_post_reset: got %0d want %0d", frame_count, exp_frames); end
        checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL errors_post_reset: got %0d want 0", error_count); end
    endtask

    initial begin
        test_reset();
        test_frame_64();
        test_short_frame();
        test_random_frames();
        test_back_to_back();
        test_underrun();
        test_oversize();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
